decode_stage: RTL and testbench

- Registered, handshaked RV32I decode stage. Sits between fetch and execute in the pipelined core.
- Each cycle it accepts one instruction and its PC, and extracts rs1, rs2 and rd.
- It builds the sign-extended immediate, an ALU opcode and the operand selects, plus memory, branch and jump controls.
- It presents all of these as one registered control word with a valid/ready handshake.
- It adds three things the single-cycle decoder lacks: load-use interlock (one bubble), synchronous flush, and illegal-instruction flagging.

---
 rtl/decode_stage.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready handshake, load-use interlock,
// synchronous flush and illegal-instruction flagging.
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inInstr,
  input  logic [XLEN-1:0] inPc,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outPc,
  output logic [4:0]      outRs1,
  output logic [4:0]      outRs2,
  output logic [4:0]      outRd,
  output logic [XLEN-1:0] outImm,
  output logic [3:0]      outAluOp,
  output logic [1:0]      outAluSrcA,
  output logic [1:0]      outAluSrcB,
  output logic            outRegWrite,
  output logic            outMemRead,
  output logic            outMemWrite,
  output logic            outBranch,
  output logic            outJump,
  output logic            outJalr,
  output logic            outIllegal,
  output logic [2:0]      outFunc3
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_EQ = 4'd10, ALU_NE = 4'd11,
    ALU_GE = 4'd12, ALU_GEU = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic [1:0]      src_a;
    logic [1:0]      src_b;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
    logic [2:0]      func3;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  ctrl_t       ctrl_d, ctrl_q;
  logic        valid_q;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm32;
  logic        legal, load_use, in_xfer, out_xfer;

  function automatic alu_op_e alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e alu_branch(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_EQ;
      3'd1:    return ALU_NE;
      3'd4:    return ALU_SLT;
      3'd5:    return ALU_GE;
      3'd6:    return ALU_SLTU;
      3'd7:    return ALU_GEU;
      default: return ALU_ADD;
    endcase
  endfunction

  assign opcode = inInstr[6:0];
  assign rd     = inInstr[11:7];
  assign func3  = inInstr[14:12];
  assign rs1    = inInstr[19:15];
  assign rs2    = inInstr[24:20];
  assign func7  = inInstr[31:25];

  always_comb begin
    ctrl_d    = '0;
    legal     = 1'b1;
    imm32     = '0;
    ctrl_d.pc = inPc;
    case (opcode)
      OP_R: begin
        legal  = (func7 == 7'h00) || (func7 == 7'h20 && (func3 == 3'd0 || func3 == 3'd5));
        {ctrl_d.rs1, ctrl_d.rs2, ctrl_d.rd} = {rs1, rs2, rd};
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = alu_arith(func3, func7[5]);
      end
      OP_IMM: begin
        {ctrl_d.rs1, ctrl_d.rd} = {rs1, rd};
        ctrl_d.src_b     = 2'd1;
        ctrl_d.reg_write = 1'b1;
        if (func3 == 3'd1 || func3 == 3'd5) begin
          // Shift amount is unsigned; func7 only selects SRAI.
          imm32 = {27'b0, inInstr[24:20]};
          legal = (func7 == 7'h00) || (func3 == 3'd5 && func7 == 7'h20);
          ctrl_d.alu_op = alu_arith(func3, func7[5]);
        end else begin
          imm32 = {{20{inInstr[31]}}, inInstr[31:20]};
          ctrl_d.alu_op = alu_arith(func3, 1'b0);
        end
      end
      OP_LOAD: begin
        legal = func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        {ctrl_d.rs1, ctrl_d.rd} = {rs1, rd};
        imm32 = {{20{inInstr[31]}}, inInstr[31:20]};
        ctrl_d.src_b     = 2'd1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.func3     = func3;
      end
      OP_STORE: begin
        legal = (func3 <= 3'd2);
        {ctrl_d.rs1, ctrl_d.rs2} = {rs1, rs2};
        imm32 = {{20{inInstr[31]}}, inInstr[31:25], inInstr[11:7]};
        ctrl_d.src_b     = 2'd1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.func3     = func3;
      end
      OP_BRANCH: begin
        legal = (func3 != 3'd2) && (func3 != 3'd3);
        {ctrl_d.rs1, ctrl_d.rs2} = {rs1, rs2};
        imm32 = {{19{inInstr[31]}}, inInstr[31], inInstr[7], inInstr[30:25], inInstr[11:8], 1'b0};
        ctrl_d.branch = 1'b1;
        ctrl_d.func3  = func3;
        ctrl_d.alu_op = alu_branch(func3);
      end
      OP_JAL: begin
        ctrl_d.rd = rd;
        imm32 = {{11{inInstr[31]}}, inInstr[31], inInstr[19:12], inInstr[20], inInstr[30:21], 1'b0};
        {ctrl_d.src_a, ctrl_d.src_b} = {2'd1, 2'd2};
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_JALR: begin
        legal = (func3 == 3'd0);
        {ctrl_d.rs1, ctrl_d.rd} = {rs1, rd};
        imm32 = {{20{inInstr[31]}}, inInstr[31:20]};
        {ctrl_d.src_a, ctrl_d.src_b} = {2'd1, 2'd2};
        ctrl_d.jump      = 1'b1;
        ctrl_d.jalr      = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_d.rd = rd;
        imm32 = {inInstr[31:12], 12'b0};
        ctrl_d.src_a     = (opcode == OP_LUI) ? 2'd2 : 2'd1;
        ctrl_d.src_b     = 2'd1;
        ctrl_d.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    ctrl_d.imm = XLEN'($signed(imm32));
    if (!legal) begin
      ctrl_d         = '0;
      ctrl_d.pc      = inPc;
      ctrl_d.illegal = 1'b1;
    end
    if (ctrl_d.rd == 5'd0) ctrl_d.reg_write = 1'b0;
  end

  // Unused source fields are already zero, so a zero match is excluded by rd != 0.
  assign load_use = HAZARD_EN && valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                    ((ctrl_d.rs1 == ctrl_q.rd) || (ctrl_d.rs2 == ctrl_q.rd));
  assign inReady  = !flush && !load_use && (!valid_q || outReady);
  assign in_xfer  = inValid && inReady;
  assign out_xfer = valid_q && outReady;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_d;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign outValid    = valid_q;
  assign outPc       = ctrl_q.pc;
  assign outRs1      = ctrl_q.rs1;
  assign outRs2      = ctrl_q.rs2;
  assign outRd       = ctrl_q.rd;
  assign outImm      = ctrl_q.imm;
  assign outAluOp    = ctrl_q.alu_op;
  assign outAluSrcA  = ctrl_q.src_a;
  assign outAluSrcB  = ctrl_q.src_b;
  assign outRegWrite = ctrl_q.reg_write;
  assign outMemRead  = ctrl_q.mem_read;
  assign outMemWrite = ctrl_q.mem_write;
  assign outBranch   = ctrl_q.branch;
  assign outJump     = ctrl_q.jump;
  assign outJalr     = ctrl_q.jalr;
  assign outIllegal  = ctrl_q.illegal;
  assign outFunc3    = ctrl_q.func3;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by randomized traffic
// against an ISA-level reference decoder and a transfer-level pipeline model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn, inValid, inReady, flush, outValid, outReady;
  logic [31:0] inInstr, inPc, outPc, outImm;
  logic [4:0]  outRs1, outRs2, outRd;
  logic [3:0]  outAluOp;
  logic [1:0]  outAluSrcA, outAluSrcB;
  logic        outRegWrite, outMemRead, outMemWrite, outBranch, outJump, outJalr, outIllegal;
  logic [2:0]  outFunc3;

  int checks = 0;
  int failures = 0;

  decode_stage #(.XLEN(32), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .inValid(inValid), .inReady(inReady), .inInstr(inInstr),
    .inPc(inPc), .flush(flush), .outValid(outValid), .outReady(outReady), .outPc(outPc),
    .outRs1(outRs1), .outRs2(outRs2), .outRd(outRd), .outImm(outImm), .outAluOp(outAluOp),
    .outAluSrcA(outAluSrcA), .outAluSrcB(outAluSrcB), .outRegWrite(outRegWrite),
    .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outBranch(outBranch),
    .outJump(outJump), .outJalr(outJalr), .outIllegal(outIllegal), .outFunc3(outFunc3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  sa, sb;
    logic        regw, memr, memw, br, jmp, jalr, ill;
    logic [2:0]  f3;
  } ctrl_t;

  ctrl_t exp_w;
  bit    exp_v, exp_zero;

  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decoder: immediates rebuilt arithmetically from the ISA bit layout.
  function automatic ctrl_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    ctrl_t c;
    int op, f3, f7, imm_i, imm_s, imm_b, imm_j, imm_u;
    bit ok;
    int alu_r[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int alu_b[8] = '{10, 11, 0, 0, 3, 12, 4, 13};
    c = '0;
    ok = 1'b1;
    op = int'(i[6:0]);
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    imm_i = int'($signed(i) >>> 20);
    imm_s = int'($signed(i) >>> 25) * 32 + int'(i[11:7]);
    imm_b = int'($signed(i) >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    imm_j = int'($signed(i) >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    imm_u = int'(i & 32'hFFFF_F000);
    case (op)
      'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        c.rs1 = i[19:15]; c.rs2 = i[24:20]; c.rd = i[11:7]; c.regw = 1'b1;
        c.alu = 4'((f7 == 32 && f3 == 0) ? 1 : (f7 == 32 && f3 == 5) ? 7 : alu_r[f3]);
      end
      'h13: begin
        c.rs1 = i[19:15]; c.rd = i[11:7]; c.regw = 1'b1; c.sb = 2'd1;
        if (f3 == 1 || f3 == 5) begin
          ok = (f7 == 0) || (f3 == 5 && f7 == 32);
          c.imm = 32'(int'(i[24:20]));
          c.alu = 4'((f3 == 1) ? 2 : (f7 == 32) ? 7 : 6);
        end else begin
          c.imm = imm_i;
          c.alu = 4'(alu_r[f3]);
        end
      end
      'h03: begin
        ok = (f3 != 3) && (f3 != 6) && (f3 != 7);
        c.rs1 = i[19:15]; c.rd = i[11:7]; c.sb = 2'd1; c.imm = imm_i;
        c.memr = 1'b1; c.regw = 1'b1; c.f3 = 3'(f3);
      end
      'h23: begin
        ok = (f3 <= 2);
        c.rs1 = i[19:15]; c.rs2 = i[24:20]; c.sb = 2'd1; c.imm = imm_s;
        c.memw = 1'b1; c.f3 = 3'(f3);
      end
      'h63: begin
        ok = (f3 != 2) && (f3 != 3);
        c.rs1 = i[19:15]; c.rs2 = i[24:20]; c.imm = imm_b;
        c.br = 1'b1; c.f3 = 3'(f3); c.alu = 4'(alu_b[f3]);
      end
      'h6F: begin
        c.rd = i[11:7]; c.sa = 2'd1; c.sb = 2'd2; c.imm = imm_j; c.jmp = 1'b1; c.regw = 1'b1;
      end
      'h67: begin
        ok = (f3 == 0);
        c.rs1 = i[19:15]; c.rd = i[11:7]; c.sa = 2'd1; c.sb = 2'd2; c.imm = imm_i;
        c.jmp = 1'b1; c.jalr = 1'b1; c.regw = 1'b1;
      end
      'h37, 'h17: begin
        c.rd = i[11:7]; c.sa = (op == 'h37) ? 2'd2 : 2'd1; c.sb = 2'd1; c.imm = imm_u; c.regw = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0;
      c.ill = 1'b1;
    end
    c.pc = pc;
    if (c.rd == 5'd0) c.regw = 1'b0;
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[6:0] = (k == 9) ? 7'($urandom) : OPS[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0, 1:    w[31:25] = 7'h00;
      2:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic compare_word();
    check("pc", 64'(outPc), 64'(exp_w.pc));
    check("imm", 64'(outImm), 64'(exp_w.imm));
    check("regs", 64'({outRs1, outRs2, outRd}), 64'({exp_w.rs1, exp_w.rs2, exp_w.rd}));
    check("alu", 64'({outAluOp, outAluSrcA, outAluSrcB}), 64'({exp_w.alu, exp_w.sa, exp_w.sb}));
    check("ctl", 64'({outRegWrite, outMemRead, outMemWrite, outBranch, outJump, outJalr, outIllegal, outFunc3}),
          64'({exp_w.regw, exp_w.memr, exp_w.memw, exp_w.br, exp_w.jmp, exp_w.jalr, exp_w.ill, exp_w.f3}));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    ctrl_t dec;
    bit lu, rdy, inx, outx;
    @(negedge clk);
    dec = ref_decode(inInstr, inPc);
    lu  = exp_v && exp_w.memr && exp_w.rd != 0 &&
          ((dec.rs1 != 0 && dec.rs1 == exp_w.rd) || (dec.rs2 != 0 && dec.rs2 == exp_w.rd));
    rdy = !flush && !lu && (!exp_v || outReady);
    check("inReady", 64'(inReady), 64'(rdy));
    check("outValid", 64'(outValid), 64'(exp_v));
    if (exp_v || exp_zero) compare_word();
    inx  = inValid && rdy;
    outx = exp_v && outReady;
    @(posedge clk);
    if (!rstn) begin
      exp_v = 1'b0; exp_w = '0; exp_zero = 1'b1;
    end else if (flush) begin
      exp_v = 1'b0;
    end else if (inx) begin
      exp_v = 1'b1; exp_w = dec; exp_zero = 1'b0;
    end else if (outx) begin
      exp_v = 1'b0;
    end
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'hFFD0_8293;
  localparam logic [31:0] LW   = 32'h0001_2303;
  localparam logic [31:0] ADD  = 32'h0013_03B3;
  localparam logic [31:0] SUB  = 32'h4031_0433;
  localparam logic [31:0] BAD [3] = '{32'h0000_007F, 32'h0000_2063, 32'h8050_D293};

  initial begin
    rstn = 1'b0; inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    inInstr = 32'h0; inPc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    exp_v = 1'b0; exp_w = '0; exp_zero = 1'b1;
    check("rst_valid", 64'(outValid), 64'd0);
    compare_word();
    rstn = 1'b1;

    // addi x5,x1,-3 with single-cycle latency
    inInstr = ADDI; inPc = 32'h100; inValid = 1'b1;
    cycle();
    inValid = 1'b0; #1;
    check("addi_valid", 64'(outValid), 64'd1);
    check("addi_imm", 64'(outImm), 64'hFFFF_FFFD);
    check("addi_alu", 64'({outAluOp, outAluSrcB}), 64'({4'd0, 2'd1}));
    check("addi_regs", 64'({outRd, outRs2, outRegWrite}), 64'({5'd5, 5'd0, 1'b1}));

    // reset while a word is held
    outReady = 1'b0; rstn = 1'b0;
    cycle();
    #1;
    check("midrst_valid", 64'(outValid), 64'd0);
    check("midrst_word", 64'({outImm, outRd, outRegWrite}), 64'd0);
    rstn = 1'b1; outReady = 1'b1; #1;
    check("midrst_ready", 64'(inReady), 64'd1);

    // load-use: lw x6 then add x7,x6,x1
    inInstr = LW; inPc = 32'h200; inValid = 1'b1;
    cycle();
    inInstr = ADD; inPc = 32'h204; #1;
    check("lu_stall", 64'(inReady), 64'd0);
    cycle();
    #1;
    check("lu_bubble", 64'({outValid, inReady}), 64'({1'b0, 1'b1}));
    cycle();
    #1;
    check("lu_add", 64'({outValid, outRd, outRs1, outRs2}), 64'({1'b1, 5'd7, 5'd6, 5'd1}));

    // backpressure holding sub
    inInstr = SUB; inPc = 32'h208;
    cycle();
    outReady = 1'b0; inInstr = ADDI; inPc = 32'h20C;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold", 64'({inReady, outValid, outAluOp, outRd}), 64'({1'b0, 1'b1, 4'd1, 5'd8}));
      cycle();
    end
    outReady = 1'b1; #1;
    check("bp_release", 64'(inReady), 64'd1);
    cycle();
    #1;
    check("bp_next", 64'(outImm), 64'hFFFF_FFFD);

    // flush kills both held and offered words
    outReady = 1'b0; flush = 1'b1; inInstr = SUB; #1;
    check("fl_ready", 64'(inReady), 64'd0);
    cycle();
    #1;
    check("fl_valid", 64'(outValid), 64'd0);
    flush = 1'b0; inValid = 1'b0;
    cycle();
    #1;
    check("fl_quiet", 64'(outValid), 64'd0);

    // illegal encodings still flow, with every enable cleared
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inInstr = BAD[k]; inValid = 1'b1;
      cycle();
      inValid = 1'b0; #1;
      check("ill_flag", 64'({outValid, outIllegal}), 64'({1'b1, 1'b1}));
      check("ill_en", 64'({outRegWrite, outMemRead, outMemWrite, outBranch, outJump, outJalr, outRd, outRs1, outRs2}), 64'd0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rstn     = ($urandom_range(0, 199) != 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      inInstr  = rand_instr();
      inPc     = $urandom & 32'hFFFF_FFFC;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
